// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and address helpers for the HD44780-style receptor.
package lcd_pkg;

  localparam int unsigned BUS_W    = 11;
  localparam int unsigned DATA_MSB = 10;
  localparam int unsigned DATA_LSB = 3;
  localparam int unsigned E_BIT    = 2;
  localparam int unsigned RW_BIT   = 1;
  localparam int unsigned RS_BIT   = 0;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE_MASK  = 7'h70;
  localparam logic [7:0] BLANK_CHAR = 8'h20;

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  typedef enum logic [1:0] {StIdle, StExec, StBusy} state_e;

  function automatic logic addr_valid(input logic [6:0] a);
    return ((a & LINE_MASK) == LINE0_BASE) || ((a & LINE_MASK) == LINE1_BASE);
  endfunction

  // Step within a 16-column line; crossing a line end wraps onto the other line.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a[3:0] == 4'hF) return a[6] ? LINE0_BASE : LINE1_BASE;
      return a + 7'd1;
    end
    if (a[3:0] == 4'h0) return (a[6] ? LINE0_BASE : LINE1_BASE) | 7'h0F;
    return a - 7'd1;
  endfunction

  function automatic logic [4:0] cell_index(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  function automatic logic is_long_op(input logic [7:0] d);
    return ((d & ~(OP_CLEAR | OP_HOME)) == 8'h00) && (d != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_receptor_if.sv
// LCD bus from the transmitter plus the receptor's status and read-back signals.
interface lcd_receptor_if;
  import lcd_pkg::*;

  logic [BUS_W-1:0] salida;
  logic             busy;
  logic [6:0]       ddram_addr;
  logic             display_on;
  logic             cursor_on;
  logic             blink_on;
  logic             entry_inc;
  logic             entry_shift;
  logic             cmd_err;
  logic [7:0]       wr_count;
  logic [4:0]       rd_addr;
  logic [7:0]       rd_data;

  modport master (
    output salida, rd_addr,
    input  busy, ddram_addr, display_on, cursor_on, blink_on, entry_inc, entry_shift,
    input  cmd_err, wr_count, rd_data
  );

  modport slave (
    input  salida, rd_addr,
    output busy, ddram_addr, display_on, cursor_on, blink_on, entry_inc, entry_shift,
    output cmd_err, wr_count, rd_data
  );
endinterface

// File: rtl/lcd_ddram.sv
// 32x8 character store: synchronous write, synchronous clear to blanks, async read.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_we,
  input  logic [4:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [4:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [32];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= BLANK_CHAR;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lcd_receptor.sv
// HD44780-style command receptor: samples the bus on E falling edges, decodes
// instructions/data into DDRAM and control state, and models the busy flag.
module lcd_receptor
  import lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES  = 40,
  parameter int unsigned CLEAR_CYCLES = 1600
) (
  input logic           clk,
  input logic           reset,
  lcd_receptor_if.slave lcd
);

  localparam int unsigned MaxCycles = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] BusyLoad  = CntW'(BUSY_CYCLES);
  localparam logic [CntW-1:0] ClearLoad = CntW'(CLEAR_CYCLES);

  state_e           r_state, w_state_d;
  logic [BUS_W-1:0] r_bus;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [7:0]       r_cmd, w_cmd_d;
  logic             r_cmd_rs, w_cmd_rs_d;
  logic [6:0]       r_addr, w_addr_d;
  logic             r_disp, w_disp_d;
  logic             r_cur, w_cur_d;
  logic             r_blink, w_blink_d;
  logic             r_inc, w_inc_d;
  logic             r_shift, w_shift_d;
  logic             r_err, w_err_d;
  logic [7:0]       r_wr_cnt, w_wr_cnt_d;

  logic       w_fall, w_wr_req, w_clr_cmd, w_mem_we;
  logic [7:0] w_bus_data;

  assign w_bus_data = r_bus[DATA_MSB:DATA_LSB];
  assign w_fall     = r_bus[E_BIT] & ~lcd.salida[E_BIT];
  assign w_wr_req   = w_fall & ~r_bus[RW_BIT];

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_cmd_d    = r_cmd;
    w_cmd_rs_d = r_cmd_rs;
    w_addr_d   = r_addr;
    w_disp_d   = r_disp;
    w_cur_d    = r_cur;
    w_blink_d  = r_blink;
    w_inc_d    = r_inc;
    w_shift_d  = r_shift;
    w_err_d    = 1'b0;
    w_wr_cnt_d = r_wr_cnt;
    w_clr_cmd  = 1'b0;
    w_mem_we   = 1'b0;

    // The counter runs from acceptance, so busy lasts exactly the loaded count.
    unique case (r_state)
      StIdle: begin
        if (w_wr_req) begin
          w_state_d  = StExec;
          w_cmd_d    = w_bus_data;
          w_cmd_rs_d = r_bus[RS_BIT];
          w_cnt_d    = (!r_bus[RS_BIT] && is_long_op(w_bus_data)) ? ClearLoad : BusyLoad;
        end
      end
      StExec, StBusy: begin
        w_err_d   = w_wr_req;
        w_cnt_d   = r_cnt - CntW'(1);
        w_state_d = (r_cnt <= CntW'(1)) ? StIdle : StBusy;
      end
      default: w_state_d = StIdle;
    endcase

    if (r_state == StExec) begin
      if (r_cmd_rs) begin
        w_mem_we = 1'b1;
        w_addr_d = addr_step(r_addr, r_inc);
        if (r_wr_cnt != 8'hFF) w_wr_cnt_d = r_wr_cnt + 8'd1;
      end else if ((r_cmd & OP_DDRAM) != 8'h00) begin
        if (addr_valid(r_cmd[6:0])) w_addr_d = r_cmd[6:0];
        else                        w_err_d  = 1'b1;
      end else if ((r_cmd & (OP_CGRAM | OP_FUNC)) == 8'h00) begin
        if ((r_cmd & OP_SHIFT) != 8'h00) begin
          w_addr_d = addr_step(r_addr, r_cmd[2]);
        end else if ((r_cmd & OP_DISPLAY) != 8'h00) begin
          w_disp_d  = r_cmd[2];
          w_cur_d   = r_cmd[1];
          w_blink_d = r_cmd[0];
        end else if ((r_cmd & OP_ENTRY) != 8'h00) begin
          w_inc_d   = r_cmd[1];
          w_shift_d = r_cmd[0];
        end else if ((r_cmd & OP_HOME) != 8'h00) begin
          w_addr_d = LINE0_BASE;
        end else if ((r_cmd & OP_CLEAR) != 8'h00) begin
          w_clr_cmd  = 1'b1;
          w_addr_d   = LINE0_BASE;
          w_inc_d    = 1'b1;
          w_wr_cnt_d = 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_bus    <= '0;
      r_cnt    <= '0;
      r_cmd    <= 8'h00;
      r_cmd_rs <= 1'b0;
      r_addr   <= LINE0_BASE;
      r_disp   <= 1'b0;
      r_cur    <= 1'b0;
      r_blink  <= 1'b0;
      r_inc    <= 1'b1;
      r_shift  <= 1'b0;
      r_err    <= 1'b0;
      r_wr_cnt <= 8'd0;
    end else begin
      r_state  <= w_state_d;
      r_bus    <= lcd.salida;
      r_cnt    <= w_cnt_d;
      r_cmd    <= w_cmd_d;
      r_cmd_rs <= w_cmd_rs_d;
      r_addr   <= w_addr_d;
      r_disp   <= w_disp_d;
      r_cur    <= w_cur_d;
      r_blink  <= w_blink_d;
      r_inc    <= w_inc_d;
      r_shift  <= w_shift_d;
      r_err    <= w_err_d;
      r_wr_cnt <= w_wr_cnt_d;
    end
  end

  lcd_ddram u_ddram (
    .clk     (clk),
    .i_clr   (reset | w_clr_cmd),
    .i_we    (w_mem_we),
    .i_waddr (cell_index(r_addr)),
    .i_wdata (r_cmd),
    .i_raddr (lcd.rd_addr),
    .o_rdata (lcd.rd_data)
  );

  assign lcd.busy        = (r_state != StIdle);
  assign lcd.ddram_addr  = r_addr;
  assign lcd.display_on  = r_disp;
  assign lcd.cursor_on   = r_cur;
  assign lcd.blink_on    = r_blink;
  assign lcd.entry_inc   = r_inc;
  assign lcd.entry_shift = r_shift;
  assign lcd.cmd_err     = r_err;
  assign lcd.wr_count    = r_wr_cnt;

endmodule

// File: tb/tb_lcd_receptor.sv
// Bench for lcd_receptor: directed vector table, corner sequences and random
// traffic checked against a position-based behavioural display model.
module tb_lcd_receptor;
  import lcd_pkg::*;

  localparam int unsigned BusyN  = 5;
  localparam int unsigned ClearN = 17;

  logic clk = 1'b0;
  logic reset;
  always #50 clk = ~clk;

  lcd_receptor_if lcd ();

  lcd_receptor #(
    .BUSY_CYCLES  (BusyN),
    .CLEAR_CYCLES (ClearN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .lcd   (lcd)
  );

  int checks   = 0;
  int failures = 0;

  // Model: cells indexed line*16+col, cursor as a linear position 0..31.
  byte unsigned m_mem [32];
  int m_pos, m_wrc, m_left, run, last_run;
  bit m_disp, m_cur, m_blink, m_inc, m_shift;

  typedef struct {
    logic [7:0] d;
    logic       rs;
    logic [6:0] exp_addr;
    logic [7:0] exp_wrc;
  } vec_t;
  vec_t vecs [13];
  logic [7:0] name_bytes [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pos_to_addr(input int p);
    return (p / 16) * 64 + (p % 16);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_pos = 0; m_wrc = 0; m_left = 0;
    m_disp = 0; m_cur = 0; m_blink = 0; m_inc = 1; m_shift = 0;
  endtask

  task automatic model_apply(input byte unsigned d, input bit rs, output bit bad);
    int msb, a;
    bad = 0;
    msb = -1;
    if (rs) begin
      m_mem[m_pos] = d;
      m_pos = m_inc ? (m_pos + 1) % 32 : (m_pos + 31) % 32;
      if (m_wrc < 255) m_wrc++;
      m_left = BusyN;
      return;
    end
    for (int i = 7; i >= 0; i--) if (msb < 0 && d[i]) msb = i;
    case (msb)
      7: begin
        a = d & 127;
        if (a < 16) m_pos = a;
        else if (a >= 64 && a < 80) m_pos = a - 48;
        else bad = 1;
      end
      4: m_pos = d[2] ? (m_pos + 1) % 32 : (m_pos + 31) % 32;
      3: begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
      2: begin m_inc = d[1]; m_shift = d[0]; end
      1: m_pos = 0;
      0: begin
        for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
        m_pos = 0; m_inc = 1; m_wrc = 0;
      end
      default: ;
    endcase
    m_left = (msb == 0 || msb == 1) ? ClearN : BusyN;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (m_left > 0) m_left--;
  endtask

  task automatic check_busy();
    chk("busy", lcd.busy, (m_left > 0));
    if (lcd.busy === 1'b1) run++;
    else if (run != 0) begin last_run = run; run = 0; end
  endtask

  task automatic step();
    advance();
    check_busy();
  endtask

  task automatic check_state(input string tag);
    chk({tag, " ddram_addr"}, lcd.ddram_addr, pos_to_addr(m_pos));
    chk({tag, " display_on"}, lcd.display_on, m_disp);
    chk({tag, " cursor_on"}, lcd.cursor_on, m_cur);
    chk({tag, " blink_on"}, lcd.blink_on, m_blink);
    chk({tag, " entry_inc"}, lcd.entry_inc, m_inc);
    chk({tag, " entry_shift"}, lcd.entry_shift, m_shift);
    chk({tag, " wr_count"}, lcd.wr_count, m_wrc);
    for (int i = 0; i < 32; i++) begin
      lcd.rd_addr = 5'(i);
      #1;
      chk($sformatf("%s cell%0d", tag, i), lcd.rd_data, m_mem[i]);
    end
  endtask

  task automatic read_cell(input logic [4:0] idx, output logic [7:0] val);
    lcd.rd_addr = idx;
    #1;
    val = lcd.rd_data;
  endtask

  // One bus transfer: E high for two cycles, accepted on the falling edge.
  task automatic xfer(input byte unsigned d, input bit rs, input bit rw);
    bit pre, bad, rej;
    bad = 0;
    lcd.salida = {d, 1'b1, rw, rs};
    step();
    step();
    lcd.salida[E_BIT] = 1'b0;
    pre = (m_left > 0);
    advance();
    rej = !rw && pre;
    if (!rw && !pre) model_apply(d, rs, bad);
    check_busy();
    chk("cmd_err on accept", lcd.cmd_err, rej);
    step();
    chk("cmd_err after exec", lcd.cmd_err, bad);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (lcd.busy === 1'b1 && k < int'(ClearN) + 8) begin
      step();
      k++;
    end
    chk("idle within bound", lcd.busy, 1'b0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    byte unsigned d;
    bit rs, rw;
    int pick, gap;

    vecs[0]  = '{8'h01, 1'b0, 7'h00, 8'd0};
    vecs[1]  = '{8'h02, 1'b0, 7'h00, 8'd0};
    vecs[2]  = '{8'h0F, 1'b0, 7'h00, 8'd0};
    vecs[3]  = '{8'h43, 1'b1, 7'h01, 8'd1};
    vecs[4]  = '{8'h52, 1'b1, 7'h02, 8'd2};
    vecs[5]  = '{8'h49, 1'b1, 7'h03, 8'd3};
    vecs[6]  = '{8'h53, 1'b1, 7'h04, 8'd4};
    vecs[7]  = '{8'h54, 1'b1, 7'h05, 8'd5};
    vecs[8]  = '{8'h49, 1'b1, 7'h06, 8'd6};
    vecs[9]  = '{8'h41, 1'b1, 7'h07, 8'd7};
    vecs[10] = '{8'h8F, 1'b0, 7'h0F, 8'd7};
    vecs[11] = '{8'h41, 1'b1, 7'h40, 8'd8};
    vecs[12] = '{8'h42, 1'b1, 7'h41, 8'd9};
    name_bytes = '{8'h43, 8'h52, 8'h49, 8'h53, 8'h54, 8'h49, 8'h41};
    run = 0;
    last_run = 0;

    lcd.salida  = '0;
    lcd.rd_addr = '0;
    reset = 1'b1;
    model_reset();
    advance();
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("reset cmd_err", lcd.cmd_err, 1'b0);
    check_state("reset");

    // Directed table: init, name write, line wrap at 0x0F.
    for (int i = 0; i < 13; i++) begin
      xfer(vecs[i].d, vecs[i].rs, 1'b0);
      wait_idle();
      repeat (2) step();
      chk($sformatf("vec%0d ddram_addr", i), lcd.ddram_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d wr_count", i), lcd.wr_count, vecs[i].exp_wrc);
      check_state($sformatf("vec%0d", i));
    end
    chk("display_on", lcd.display_on, 1'b1);
    chk("cursor_on", lcd.cursor_on, 1'b1);
    chk("blink_on", lcd.blink_on, 1'b1);
    for (int i = 0; i < 7; i++) begin
      read_cell(5'(i), v);
      chk($sformatf("name cell%0d", i), v, name_bytes[i]);
    end
    read_cell(5'h0F, v);
    chk("cell 0x0F", v, 8'h41);
    read_cell(5'h10, v);
    chk("cell 0x40", v, 8'h42);

    // Write 10 cycles into a clear: rejected, clear busy length unchanged.
    xfer(8'h01, 1'b0, 1'b0);
    repeat (6) step();
    xfer(8'h58, 1'b1, 1'b0);
    wait_idle();
    chk("clear busy length", last_run, ClearN);
    read_cell(5'h00, v);
    chk("rejected write not stored", v, 8'h20);
    chk("wr_count after clear", lcd.wr_count, 8'd0);
    check_state("after clear");

    // Bad set-address, then decrement wrap from 0x40.
    xfer(8'hA0, 1'b0, 1'b0);
    wait_idle();
    chk("bad addr keeps ddram_addr", lcd.ddram_addr, 7'h00);
    xfer(8'hC0, 1'b0, 1'b0);
    wait_idle();
    xfer(8'h04, 1'b0, 1'b0);
    wait_idle();
    xfer(8'h5A, 1'b1, 1'b0);
    wait_idle();
    chk("decrement wrap addr", lcd.ddram_addr, 7'h0F);
    read_cell(5'h10, v);
    chk("decrement wrap cell", v, 8'h5A);
    check_state("decrement");

    // Reset in the middle of a busy window.
    xfer(8'h0F, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
    chk("reset mid-busy display_on", lcd.display_on, 1'b0);
    check_state("reset mid-busy");

    // E falling edge coinciding with reset is discarded.
    lcd.salida = {8'h0F, 1'b1, 1'b0, 1'b0};
    step();
    step();
    reset = 1'b1;
    lcd.salida[E_BIT] = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("fall during reset ignored", lcd.busy, 1'b0);
    check_state("fall during reset");

    // wr_count saturation.
    for (int i = 0; i < 258; i++) begin
      xfer(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      wait_idle();
    end
    chk("wr_count saturates", lcd.wr_count, 8'd255);
    check_state("saturation");

    // Random traffic including status reads and back-to-back transfers.
    for (int i = 0; i < 200; i++) begin
      pick = $urandom_range(0, 9);
      rs = (pick < 4);
      case (pick)
        4:       d = 8'h80 | 8'($urandom_range(0, 127));
        5:       d = 8'h10 | 8'($urandom_range(0, 15));
        6:       d = 8'h08 | 8'($urandom_range(0, 7));
        7:       d = 8'h04 | 8'($urandom_range(0, 3));
        8:       d = 8'($urandom_range(1, 3));
        default: d = 8'($urandom_range(0, 255));
      endcase
      rw = ($urandom_range(0, 7) == 0);
      xfer(d, rs, rw);
      check_state($sformatf("rand%0d", i));
      gap = $urandom_range(0, BusyN + 2);
      repeat (gap) step();
    end
    wait_idle();
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_receptor.md
LCD_RECEPTOR -- requirements
Module: lcd_receptor

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 40, busy time in clk cycles after any accepted instruction except clear/home.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 1600, busy time in clk cycles after clear (0x01) or return home (0x02/0x03).
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port salida, input, 11, LCD bus from the transmitter: [10:3] data byte, [2] E, [1] RW, [0] RS.
REQ-006 SHALL have port busy, output, 1, HD44780-style busy flag.
REQ-007 SHALL have port ddram_addr, output, 7, current DDRAM address counter.
REQ-008 SHALL have ports display_on, cursor_on, blink_on, entry_inc, entry_shift, outputs, 1 each, decoded control state.
REQ-009 SHALL have port cmd_err, output, 1, one-cycle pulse on a rejected transfer.
REQ-010 SHALL have port wr_count, output, 8, count of characters written since reset or clear, saturating at 255.
REQ-011 SHALL have ports rd_addr, input, 5, and rd_data, output, 8; rd_addr[4] selects line (0 = 0x00-0x0F, 1 = 0x40-0x4F), rd_addr[3:0] selects column; rd_data is combinational.

Function
REQ-012 SHALL register E and the full bus every cycle; a transfer is accepted on the first cycle where registered E=1 and current E=0 (E falling edge), using the registered data/RS/RW.
REQ-013 SHALL implement FSM IDLE -> EXEC (one cycle, decode and update) -> BUSY (count down) -> IDLE; busy=1 in EXEC and BUSY.
REQ-014 SHALL ignore any transfer accepted while busy=1 and RW=0, and pulse cmd_err.
REQ-015 SHALL treat RW=1 as a status read: no state change, no error, accepted in any state.
REQ-016 With RS=0, decode by highest set bit: 0x01 clear (all 32 cells to 0x20, ddram_addr=0, entry_inc=1, wr_count=0); 0x02/0x03 home (ddram_addr=0); 0x04-0x07 entry_inc=data[1], entry_shift=data[0]; 0x08-0x0F display_on=data[2], cursor_on=data[1], blink_on=data[0]; 0x10-0x1F cursor shift, adjusting address as in REQ-018 by data[2]; 0x20-0x3F function set, no state effect; 0x80-0xFF set address to data[6:0].
REQ-017 Set-address to a value outside 0x00-0x0F and 0x40-0x4F SHALL leave ddram_addr unchanged and pulse cmd_err; still enter BUSY.
REQ-018 With RS=1, write data to the cell at ddram_addr, then increment (entry_inc=1) or decrement; wrap: 0x0F+1 -> 0x40, 0x4F+1 -> 0x00, 0x00-1 -> 0x4F, 0x40-1 -> 0x0F.
REQ-019 SHALL increment wr_count on each RS=1 write, saturating at 255.
REQ-020 Clear and home SHALL load the busy counter with CLEAR_CYCLES; all other accepted writes load BUSY_CYCLES; busy deasserts the cycle after the counter reaches 0.
REQ-021 A falling E edge on the same cycle reset is high SHALL be discarded.

Reset
REQ-022 Reset SHALL force FSM to IDLE, busy=0, ddram_addr=0, display_on=0, cursor_on=0, blink_on=0, entry_inc=1, entry_shift=0, cmd_err=0, wr_count=0, E register=0, and all 32 cells to 0x20.
REQ-023 Reset mid-BUSY SHALL abort the countdown immediately; the next cycle is IDLE.

Structure
REQ-024 Opcode masks, line base addresses (0x00, 0x40), blank char 0x20 and bus bit positions SHALL live in shared package lcd_pkg.
REQ-025 Character storage SHALL be sub-module lcd_ddram (32x8, one synchronous write port, one combinational read port, synchronous clear).

Verification
REQ-026 Reset then 0x01, 0x02, 0x0F with E pulses spaced beyond CLEAR_CYCLES -> display_on=cursor_on=blink_on=1, ddram_addr=0x00, all rd_data=0x20.
REQ-027 Write 'C','R','I','S','T','I','A' (0x43,0x52,0x49,0x53,0x54,0x49,0x41) -> rd_addr 0-6 return those bytes, ddram_addr=0x07, wr_count=7.
REQ-028 Set address 0x8F, write 0x41 and 0x42 -> cell 0x0F=0x41, cell 0x40=0x42, ddram_addr=0x41.
REQ-029 Issue 0x01 then a data write 10 cycles later -> cmd_err pulses one cycle, write not stored, busy stays 1 for CLEAR_CYCLES total.
REQ-030 Set address 0xA0 (0x20) -> cmd_err pulse, ddram_addr unchanged; entry mode 0x04 at address 0x40 then write -> ddram_addr=0x0F.
REQ-031 Assert reset during BUSY after 0x0F -> next cycle busy=0, display_on=0, cells 0x20.
